// File: rtl/tb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pkg
//   Definitions shared by the run sequencer and the Avalon register file:
//   the sequencer state encoding, the verdict codes reported on o_status and
//   the bit positions of the core control word (reset / enable / freeze).
//   Keeping the control-word layout here means the register file and the
//   sequencer can never disagree on which bit drives which core input.
// ---------------------------------------------------------------------------
package tb_ctrl_pkg;

  // Sequencer phases, in the order a run walks through them.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Verdict codes.
  localparam logic [1:0] ST_NONE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;  // timeout or software abort

  // Control-word bit positions.
  localparam int CTRL_RESET  = 0;
  localparam int CTRL_ENABLE = 1;
  localparam int CTRL_FREEZE = 2;
  localparam int CTRL_W      = 3;

  // Control word the core should see while the sequencer sits in state s.
  // Reset is held through IDLE and CLEAR, enable only in RUN, freeze only in
  // DONE; SETTLE and DRAIN leave the core out of reset but idle.
  function automatic logic [CTRL_W-1:0] ctrl_word(input state_t s);
    logic [CTRL_W-1:0] w;
    w = '0;
    case (s)
      IDLE, CLEAR: w[CTRL_RESET]  = 1'b1;
      RUN:         w[CTRL_ENABLE] = 1'b1;
      DONE:        w[CTRL_FREEZE] = 1'b1;
      default:     w = '0;
    endcase
    return w;
  endfunction

  // True for the phases in which a run is in progress.
  function automatic logic is_busy(input state_t s);
    return (s == CLEAR) || (s == SETTLE) || (s == RUN) || (s == DRAIN);
  endfunction

endpackage : tb_ctrl_pkg

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter with a zero flag. The sequencer loads it with
//   (phase length - 1) on the edge that enters a timed phase and leaves the
//   phase on the edge where zero is seen, so a load of N-1 gives a phase of
//   exactly N cycles. The counter parks at zero once it gets there.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset (count returns to zero)
//   load       load load_value on the next edge (takes priority over count)
//   load_value value to load
//   zero       high while the registered count is zero
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule : phase_timer

// File: rtl/run_sequencer.sv
// ---------------------------------------------------------------------------
// run_sequencer
//   Autonomous controller for one arithmetic test run on the testbench core.
//   Walks the core through CLEAR -> SETTLE -> RUN -> DRAIN -> DONE, stopping
//   the RUN phase when the data counter reaches the target, when the cycle
//   timeout expires, or when software aborts. Reports a verdict and the
//   number of cycles spent in RUN.
//
// Parameters
//   RESET_CYCLES  cycles the core is held in reset during CLEAR (>= 1)
//   CNT_W         width of target / timeout / core counters / run counter
//   DLY_W         width of the settle and drain delay fields
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   i_start        one-cycle pulse, starts a run from IDLE or DONE
//   i_abort        terminates a run in progress (wins over i_start)
//   i_target       data points to run            (latched on start)
//   i_timeout      max RUN cycles, 0 = unlimited (latched on start)
//   i_settle       idle cycles before enable     (latched on start)
//   i_drain        cycles after enable drop      (latched on start)
//   i_data_ctr     core data counter  (synchronous to clk)
//   i_error_ctr    core error counter (synchronous to clk)
//   o_tb_reset / o_tb_enable / o_tb_freeze   core control lines
//   o_busy         high in CLEAR, SETTLE, RUN, DRAIN
//   o_done         high in DONE
//   o_status       0 none, 1 pass, 2 errors, 3 timeout/abort
//   o_run_cycles   cycles spent in RUN, saturating
//
//   All outputs come straight from registers. Outputs that depend only on
//   the phase are registered from the next-state value, so they change on
//   the same edge as the state itself.
// ---------------------------------------------------------------------------
module run_sequencer
  import tb_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int DLY_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_target,
  input  logic [CNT_W-1:0] i_timeout,
  input  logic [DLY_W-1:0] i_settle,
  input  logic [DLY_W-1:0] i_drain,
  input  logic [CNT_W-1:0] i_data_ctr,
  input  logic [CNT_W-1:0] i_error_ctr,
  output logic             o_tb_reset,
  output logic             o_tb_enable,
  output logic             o_tb_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_status,
  output logic [CNT_W-1:0] o_run_cycles
);

  // One timer serves CLEAR, SETTLE and DRAIN, so it must be wide enough for
  // both the delay fields and the fixed reset length.
  localparam int CLR_W = $clog2(RESET_CYCLES + 1);
  localparam int TMR_W = (DLY_W > CLR_W) ? DLY_W : CLR_W;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [1:0]        status_reg, status_next;
  logic [CNT_W-1:0]  run_cycles_reg;
  logic              timeout_flag_reg, timeout_flag_next;

  // Configuration captured on the accepted start edge.
  logic [CNT_W-1:0]  target_reg;
  logic [CNT_W-1:0]  timeout_reg;
  logic [DLY_W-1:0]  settle_reg;
  logic [DLY_W-1:0]  drain_reg;

  // Phase timer control.
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_zero;

  // Decoded events.
  logic              start_ok;    // start accepted (abort has priority)
  logic              abort_now;   // abort taken this cycle
  logic              target_hit;
  logic              timeout_hit;
  logic              enter_clear;
  logic              enter_done;

  assign start_ok    = i_start && !i_abort;
  assign target_hit  = (i_data_ctr >= target_reg);
  assign timeout_hit = (timeout_reg != '0) &&
                       ((run_cycles_reg + CNT_W'(1)) == timeout_reg);

  // -------------------------------------------------------------------------
  // Next-state decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    tmr_load          = 1'b0;
    tmr_value         = '0;
    abort_now         = 1'b0;
    timeout_flag_next = timeout_flag_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next        = CLEAR;
          tmr_load          = 1'b1;
          tmr_value         = TMR_W'(RESET_CYCLES - 1);
          timeout_flag_next = 1'b0;
        end
      end

      CLEAR: begin
        if (i_abort) begin
          state_next = DONE;
          abort_now  = 1'b1;
        end else if (tmr_zero) begin
          if (settle_reg == '0) begin
            state_next = RUN;
          end else begin
            state_next = SETTLE;
            tmr_load   = 1'b1;
            tmr_value  = TMR_W'(settle_reg - DLY_W'(1));
          end
        end
      end

      SETTLE: begin
        if (i_abort) begin
          state_next = DONE;
          abort_now  = 1'b1;
        end else if (tmr_zero) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (i_abort) begin
          state_next = DONE;
          abort_now  = 1'b1;
        end else if (target_hit || timeout_hit) begin
          // Reaching the target in the same cycle as the timeout is a pass.
          timeout_flag_next = !target_hit;
          if (drain_reg == '0) begin
            state_next = DONE;
          end else begin
            state_next = DRAIN;
            tmr_load   = 1'b1;
            tmr_value  = TMR_W'(drain_reg - DLY_W'(1));
          end
        end
      end

      DRAIN: begin
        if (i_abort) begin
          state_next = DONE;
          abort_now  = 1'b1;
        end else if (tmr_zero) begin
          state_next = DONE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign enter_clear = (state_next == CLEAR) && (state_reg != CLEAR);
  assign enter_done  = (state_next == DONE)  && (state_reg != DONE);

  // Verdict is decided on the edge that enters DONE, using the error
  // counter as it stands at that moment.
  always_comb begin
    status_next = status_reg;
    if (enter_clear) begin
      status_next = ST_NONE;
    end else if (enter_done) begin
      if (abort_now || timeout_flag_next) begin
        status_next = ST_ABORT;
      end else if (i_error_ctr != '0) begin
        status_next = ST_ERR;
      end else begin
        status_next = ST_PASS;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      ctrl_reg         <= ctrl_word(IDLE);
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      status_reg       <= ST_NONE;
      run_cycles_reg   <= '0;
      timeout_flag_reg <= 1'b0;
      target_reg       <= '0;
      timeout_reg      <= '0;
      settle_reg       <= '0;
      drain_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      ctrl_reg         <= ctrl_word(state_next);
      busy_reg         <= is_busy(state_next);
      done_reg         <= (state_next == DONE);
      status_reg       <= status_next;
      timeout_flag_reg <= timeout_flag_next;

      if (enter_clear) begin
        target_reg  <= i_target;
        timeout_reg <= i_timeout;
        settle_reg  <= i_settle;
        drain_reg   <= i_drain;
      end

      // Every cycle spent in RUN is counted, including the exit cycle.
      if (enter_clear) begin
        run_cycles_reg <= '0;
      end else if ((state_reg == RUN) && (run_cycles_reg != '1)) begin
        run_cycles_reg <= run_cycles_reg + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shared phase timer
  // -------------------------------------------------------------------------
  phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_tb_reset   = ctrl_reg[CTRL_RESET];
  assign o_tb_enable  = ctrl_reg[CTRL_ENABLE];
  assign o_tb_freeze  = ctrl_reg[CTRL_FREEZE];
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;
  assign o_status     = status_reg;
  assign o_run_cycles = run_cycles_reg;

endmodule : run_sequencer
